// File: rtl/edge_event_arbiter.sv
// Multi-channel edge-event controller: per-channel edge detection with mode filter,
// pending latch with sticky overflow, and a round-robin scheduled valid/ready event slot.
module edge_event_arbiter #(
   parameter  int unsigned N_CH = 4,
   localparam int unsigned ID_W = $clog2(N_CH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [N_CH-1:0]   a_i,
   input  logic [2*N_CH-1:0] mode_i,
   output logic              evt_valid_o,
   input  logic              evt_ready_i,
   output logic [ID_W-1:0]   evt_id_o,
   output logic              evt_rise_o,
   output logic [N_CH-1:0]   ovf_o,
   input  logic              ovf_clr_i
);

   localparam int unsigned PW = ID_W + 1;

   logic [N_CH-1:0] a_ff;
   logic [N_CH-1:0] pend;
   logic [N_CH-1:0] pend_rise;
   logic [ID_W-1:0] ptr;

   logic [N_CH-1:0] rise;
   logic [N_CH-1:0] fall;
   logic [N_CH-1:0] ev;
   logic            slot_free;
   logic            gnt_vld;
   logic [ID_W-1:0] gnt_id;
   logic [PW-1:0]   idx;
   logic [N_CH-1:0] take;
   logic [N_CH-1:0] pend_nxt;
   logic [N_CH-1:0] pend_rise_nxt;
   logic [N_CH-1:0] ovf_set;

   assign rise      = ~a_ff & a_i;
   assign fall      = a_ff & ~a_i;
   assign slot_free = ~evt_valid_o | evt_ready_i;

   // Mode filter: bit 0 enables rising, bit 1 enables falling
   always_comb begin
      ev = '0;
      for (int i = 0; i < int'(N_CH); i++) begin
         ev[i] = (rise[i] & mode_i[2*i]) | (fall[i] & mode_i[2*i+1]);
      end
   end

   // Round-robin search from ptr+1 with wrap; indices are reduced modulo N_CH
   always_comb begin
      gnt_vld = 1'b0;
      gnt_id  = '0;
      idx     = '0;
      for (int unsigned k = 1; k <= N_CH; k++) begin
         idx = PW'(ptr) + PW'(k);
         if (idx >= PW'(N_CH)) begin
            idx = idx - PW'(N_CH);
         end
         if (slot_free && !gnt_vld && pend[idx[ID_W-1:0]]) begin
            gnt_vld = 1'b1;
            gnt_id  = idx[ID_W-1:0];
         end
      end
   end

   // Pending update: a consumed channel may immediately re-arm without overflow
   always_comb begin
      take          = '0;
      pend_nxt      = pend;
      pend_rise_nxt = pend_rise;
      ovf_set       = '0;
      if (gnt_vld) begin
         take[gnt_id] = 1'b1;
      end
      for (int i = 0; i < int'(N_CH); i++) begin
         if (take[i]) begin
            pend_nxt[i] = ev[i];
            if (ev[i]) begin
               pend_rise_nxt[i] = rise[i];
            end
         end else if (ev[i]) begin
            if (!pend[i]) begin
               pend_nxt[i]      = 1'b1;
               pend_rise_nxt[i] = rise[i];
            end else begin
               ovf_set[i] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         a_ff        <= '0;
         pend        <= '0;
         pend_rise   <= '0;
         ovf_o       <= '0;
         evt_valid_o <= 1'b0;
         evt_id_o    <= '0;
         evt_rise_o  <= 1'b0;
         ptr         <= ID_W'(N_CH - 1);
      end else begin
         a_ff      <= a_i;
         pend      <= pend_nxt;
         pend_rise <= pend_rise_nxt;
         ovf_o     <= (ovf_clr_i ? '0 : ovf_o) | ovf_set;
         if (slot_free) begin
            if (gnt_vld) begin
               evt_valid_o <= 1'b1;
               evt_id_o    <= gnt_id;
               evt_rise_o  <= pend_rise[gnt_id];
               ptr         <= gnt_id;
            end else begin
               evt_valid_o <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Randomized and directed bench for edge_event_arbiter against a cycle-level
// reference model built from the event/pending/slot rules.
module tb_edge_event_arbiter;

   localparam int unsigned N  = 4;
   localparam int unsigned IW = $clog2(N);

   logic           clk;
   logic           reset;
   logic [N-1:0]   a_i;
   logic [2*N-1:0] mode_i;
   logic           evt_valid_o;
   logic           evt_ready_i;
   logic [IW-1:0]  evt_id_o;
   logic           evt_rise_o;
   logic [N-1:0]   ovf_o;
   logic           ovf_clr_i;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   logic [N-1:0] m_aff, m_pend, m_prise, m_ovf;
   logic         m_valid, m_rise;
   int           m_id, m_ptr;

   edge_event_arbiter #(.N_CH(N)) dut (
      .clk         (clk),
      .reset       (reset),
      .a_i         (a_i),
      .mode_i      (mode_i),
      .evt_valid_o (evt_valid_o),
      .evt_ready_i (evt_ready_i),
      .evt_id_o    (evt_id_o),
      .evt_rise_o  (evt_rise_o),
      .ovf_o       (ovf_o),
      .ovf_clr_i   (ovf_clr_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_aff = '0; m_pend = '0; m_prise = '0; m_ovf = '0;
      m_valid = 1'b0; m_rise = 1'b0; m_id = 0; m_ptr = N - 1;
   endtask

   task automatic model_step(input logic [N-1:0] a, input logic [2*N-1:0] m,
                             input logic rdy, input logic clr);
      logic free;
      int g, c;
      logic [N-1:0] r, f, e, np, npr, os;
      free = !m_valid || rdy;
      g = -1;
      for (int i = 0; i < N; i++) begin
         r[i] = !m_aff[i] && a[i];
         f[i] = m_aff[i] && !a[i];
         e[i] = (r[i] && m[2*i]) || (f[i] && m[2*i+1]);
      end
      if (free) begin
         for (int k = 1; k <= N; k++) begin
            c = (m_ptr + k) % N;
            if (g < 0 && m_pend[c]) g = c;
         end
      end
      np = m_pend; npr = m_prise; os = '0;
      for (int i = 0; i < N; i++) begin
         if (i == g) begin
            np[i] = e[i];
            if (e[i]) npr[i] = r[i];
         end else if (e[i]) begin
            if (!m_pend[i]) begin
               np[i] = 1'b1; npr[i] = r[i];
            end else begin
               os[i] = 1'b1;
            end
         end
      end
      if (free) begin
         if (g >= 0) begin
            m_valid = 1'b1; m_id = g; m_rise = m_prise[g]; m_ptr = g;
         end else begin
            m_valid = 1'b0;
         end
      end
      m_pend  = np;
      m_prise = npr;
      m_ovf   = (clr ? '0 : m_ovf) | os;
      m_aff   = a;
   endtask

   task automatic compare_all();
      chk("valid", 32'(evt_valid_o), 32'(m_valid));
      if (m_valid) begin
         chk("id", 32'(evt_id_o), 32'(m_id));
         chk("rise", 32'(evt_rise_o), 32'(m_rise));
      end
      chk("ovf", 32'(ovf_o), 32'(m_ovf));
   endtask

   // Called at a negedge: apply inputs, step model at posedge, compare at next negedge
   task automatic cycle(input logic [N-1:0] a, input logic [2*N-1:0] m,
                        input logic rdy, input logic clr);
      a_i = a; mode_i = m; evt_ready_i = rdy; ovf_clr_i = clr;
      @(posedge clk);
      model_step(a, m, rdy, clr);
      @(negedge clk);
      compare_all();
   endtask

   // Async reset pulse between edges; outputs must clear without a clock edge
   task automatic do_reset();
      reset = 1'b0; a_i = '0; evt_ready_i = 1'b0; ovf_clr_i = 1'b0;
      #1;
      model_reset();
      chk("rst_valid", 32'(evt_valid_o), 32'd0);
      chk("rst_ovf", 32'(ovf_o), 32'd0);
      chk("rst_id", 32'(evt_id_o), 32'd0);
      #1;
      reset = 1'b1;
   endtask

   initial begin
      logic [N-1:0]   na;
      logic [2*N-1:0] m;
      int rp, tp;
      reset = 1'b0; a_i = '0; mode_i = '0; evt_ready_i = 1'b0; ovf_clr_i = 1'b0;
      model_reset();
      @(negedge clk);

      // basic rise on ch2, two-edge latency, drain
      do_reset();
      cycle(4'b0000, 8'h55, 1'b0, 1'b0);
      cycle(4'b0100, 8'h55, 1'b0, 1'b0);
      chk("t1_early", 32'(evt_valid_o), 32'd0);
      cycle(4'b0100, 8'h55, 1'b0, 1'b0);
      chk("t1_valid", 32'(evt_valid_o), 32'd1);
      chk("t1_id", 32'(evt_id_o), 32'd2);
      chk("t1_rise", 32'(evt_rise_o), 32'd1);
      cycle(4'b0100, 8'h55, 1'b1, 1'b0);
      chk("t1_drain", 32'(evt_valid_o), 32'd0);

      // simultaneous rises, round-robin from reset pointer
      do_reset();
      cycle(4'b1011, 8'hFF, 1'b1, 1'b0);
      cycle(4'b1011, 8'hFF, 1'b1, 1'b0);
      chk("t2_id0", 32'(evt_id_o), 32'd0);
      cycle(4'b1011, 8'hFF, 1'b1, 1'b0);
      chk("t2_id1", 32'(evt_id_o), 32'd1);
      cycle(4'b1011, 8'hFF, 1'b1, 1'b0);
      chk("t2_id3", 32'(evt_id_o), 32'd3);
      for (int i = 0; i < 6; i++) cycle(4'b0000, 8'hFF, 1'b1, 1'b0);
      cycle(4'b1001, 8'hFF, 1'b1, 1'b0);
      cycle(4'b1001, 8'hFF, 1'b1, 1'b0);
      cycle(4'b1001, 8'hFF, 1'b1, 1'b0);

      // overflow on ch1 while slot is stalled, then drain
      do_reset();
      cycle(4'b0000, 8'h0C, 1'b0, 1'b0);
      cycle(4'b0010, 8'h0C, 1'b0, 1'b0);
      cycle(4'b0000, 8'h0C, 1'b0, 1'b0);
      cycle(4'b0010, 8'h0C, 1'b0, 1'b0);
      chk("t3_ovf", 32'(ovf_o), 32'h2);
      chk("t3_id", 32'(evt_id_o), 32'd1);
      chk("t3_rise", 32'(evt_rise_o), 32'd1);
      cycle(4'b0010, 8'h0C, 1'b1, 1'b0);
      chk("t3_fall", 32'(evt_rise_o), 32'd0);
      cycle(4'b0010, 8'h0C, 1'b1, 1'b0);
      chk("t3_empty", 32'(evt_valid_o), 32'd0);

      // clear coinciding with a new overflow keeps the bit; clear alone clears
      cycle(4'b0000, 8'h0C, 1'b0, 1'b0);
      cycle(4'b0010, 8'h0C, 1'b0, 1'b0);
      cycle(4'b0000, 8'h0C, 1'b0, 1'b1);
      chk("t5_keep", 32'(ovf_o), 32'h2);
      cycle(4'b0000, 8'h0C, 1'b0, 1'b1);
      chk("t5_clr", 32'(ovf_o), 32'h0);

      // stalled slot with two channels pending, then async reset
      cycle(4'b0001, 8'h0F, 1'b0, 1'b0);
      cycle(4'b0000, 8'h0F, 1'b0, 1'b0);
      do_reset();
      for (int i = 0; i < 4; i++) begin
         cycle(4'b0000, 8'hFF, 1'b1, 1'b0);
         chk("t6_stale", 32'(evt_valid_o), 32'd0);
      end

      // falling-only filter and disabled channel
      cycle(4'b0001, 8'h02, 1'b1, 1'b0);
      cycle(4'b0001, 8'h02, 1'b1, 1'b0);
      cycle(4'b0001, 8'h02, 1'b1, 1'b0);
      chk("t4_norise", 32'(evt_valid_o), 32'd0);
      cycle(4'b0000, 8'h02, 1'b1, 1'b0);
      cycle(4'b0000, 8'h02, 1'b1, 1'b0);
      chk("t4_fall", 32'(evt_rise_o), 32'd0);
      cycle(4'b0000, 8'h02, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) cycle(4'b0001, 8'h00, 1'b1, 1'b0);
      for (int i = 0; i < 2; i++) cycle(4'b0000, 8'h00, 1'b1, 1'b0);
      chk("t4_off", 32'(evt_valid_o), 32'd0);

      // randomized phases with varying ready and toggle density
      for (int ph = 0; ph < 6; ph++) begin
         rp = 15 + ph * 17;
         tp = 10 + ph * 12;
         m  = (2*N)'($urandom);
         for (int c = 0; c < 250; c++) begin
            na = a_i;
            for (int i = 0; i < N; i++)
               if ($urandom_range(0, 99) < tp) na[i] = ~na[i];
            if ($urandom_range(0, 49) == 0) m = (2*N)'($urandom);
            if (ph == 3 && c == 100) do_reset();
            cycle(na, m, $urandom_range(0, 99) < rp, $urandom_range(0, 19) == 0);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
